// File: rtl/uart_pkg.sv
// Shared UART definitions: bit timing defaults, tx state encoding and the
// parity rule used by both the transmit and receive stages.
package uart_pkg;

    localparam int CLKS_PER_BIT_DEF = 16;
    localparam int FRAME_BITS_BASE  = 10;  // start + 8 data + parity

    typedef enum logic [2:0] {
        TX_IDLE   = 3'd0,
        TX_START  = 3'd1,
        TX_DATA   = 3'd2,
        TX_PARITY = 3'd3,
        TX_STOP   = 3'd4
    } tx_state_e;

    function automatic int frame_bits(input int stop_bits);
        return FRAME_BITS_BASE + stop_bits;
    endfunction

    // Even wins when both are set; neither set falls back to even.
    function automatic logic parity_calc(input logic [7:0] data,
                                         input logic       even,
                                         input logic       odd);
        if (even || !odd) begin
            return ^data;
        end
        return ~(^data);
    endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Per-bit clock counter: counts 0..CLKS_PER_BIT-1 and flags the last count.
module uart_bit_timer
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
    input  logic clk_tx,
    input  logic rst,
    input  logic clear,
    output logic bit_tick
);

    localparam int W = $clog2(CLKS_PER_BIT);

    logic [W-1:0] clk_cnt_q;
    logic [W-1:0] clk_cnt_d;

    assign bit_tick = (clk_cnt_q == W'(CLKS_PER_BIT - 1));

    always_comb begin
        clk_cnt_d = clk_cnt_q + W'(1);
        if (clear || bit_tick) begin
            clk_cnt_d = '0;
        end
    end

    always_ff @(posedge clk_tx) begin
        if (rst) begin
            clk_cnt_q <= '0;
        end else begin
            clk_cnt_q <= clk_cnt_d;
        end
    end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: start, 8 data bits LSB first, parity, 1-2 stop bits.
// All outputs are registered so the line level changes on the accepting edge.
module uart_tx
    import uart_pkg::*;
#(
    parameter int   CLKS_PER_BIT = CLKS_PER_BIT_DEF,
    parameter logic PARITY_EVEN  = 1'b1,
    parameter logic PARITY_ODD   = 1'b0,
    parameter int   STOP_BITS    = 1
) (
    input  logic       clk_tx,
    input  logic       rst,
    input  logic [7:0] tx_data,
    input  logic       tx_start,
    output logic       dataout_tx,
    output logic       tx_busy,
    output logic       tx_done
);

    localparam logic STOP_LAST = 1'(STOP_BITS - 1);

    tx_state_e  state_q, state_d;
    logic [7:0] shift_q, shift_d;
    logic [2:0] bit_idx_q, bit_idx_d;
    logic       stop_idx_q, stop_idx_d;
    logic       parity_q, parity_d;
    logic       dout_q, dout_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic       bit_tick;

    uart_bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_timer (
        .clk_tx  (clk_tx),
        .rst     (rst),
        .clear   (state_q == TX_IDLE),
        .bit_tick(bit_tick)
    );

    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        bit_idx_d  = bit_idx_q;
        stop_idx_d = stop_idx_q;
        parity_d   = parity_q;
        dout_d     = dout_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        unique case (state_q)
            TX_IDLE: begin
                dout_d = 1'b1;
                busy_d = 1'b0;
                if (tx_start && !busy_q) begin
                    state_d    = TX_START;
                    shift_d    = tx_data;
                    parity_d   = parity_calc(tx_data, PARITY_EVEN, PARITY_ODD);
                    bit_idx_d  = '0;
                    stop_idx_d = 1'b0;
                    dout_d     = 1'b0;
                    busy_d     = 1'b1;
                end
            end
            TX_START: begin
                if (bit_tick) begin
                    state_d = TX_DATA;
                    dout_d  = shift_q[0];
                end
            end
            TX_DATA: begin
                if (bit_tick) begin
                    shift_d = shift_q >> 1;
                    if (bit_idx_q == 3'd7) begin
                        state_d = TX_PARITY;
                        dout_d  = parity_q;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                        dout_d    = shift_q[1];
                    end
                end
            end
            TX_PARITY: begin
                if (bit_tick) begin
                    state_d    = TX_STOP;
                    stop_idx_d = 1'b0;
                    dout_d     = 1'b1;
                end
            end
            TX_STOP: begin
                if (bit_tick) begin
                    if (stop_idx_q == STOP_LAST) begin
                        state_d = TX_IDLE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        stop_idx_d = stop_idx_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = TX_IDLE;
                dout_d  = 1'b1;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_tx) begin
        if (rst) begin
            state_q    <= TX_IDLE;
            shift_q    <= '0;
            bit_idx_q  <= '0;
            stop_idx_q <= 1'b0;
            parity_q   <= 1'b0;
            dout_q     <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            bit_idx_q  <= bit_idx_d;
            stop_idx_q <= stop_idx_d;
            parity_q   <= parity_d;
            dout_q     <= dout_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign dataout_tx = dout_q;
    assign tx_busy    = busy_q;
    assign tx_done    = done_q;

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: three instances (even/1 stop, odd/1 stop,
// even/2 stops) driven from a vector table plus hand-written corner sequences.
module tb_uart_tx;

    logic       clk;
    logic       rst;
    logic [2:0] start_v;
    logic [7:0] data_v [3];
    logic [2:0] dout_v;
    logic [2:0] busy_v;
    logic [2:0] done_v;

    int checks;
    int failures;

    uart_tx u_even (
        .clk_tx(clk), .rst(rst), .tx_data(data_v[0]), .tx_start(start_v[0]),
        .dataout_tx(dout_v[0]), .tx_busy(busy_v[0]), .tx_done(done_v[0])
    );

    uart_tx #(.PARITY_EVEN(1'b0), .PARITY_ODD(1'b1)) u_odd (
        .clk_tx(clk), .rst(rst), .tx_data(data_v[1]), .tx_start(start_v[1]),
        .dataout_tx(dout_v[1]), .tx_busy(busy_v[1]), .tx_done(done_v[1])
    );

    uart_tx #(.STOP_BITS(2)) u_stop2 (
        .clk_tx(clk), .rst(rst), .tx_data(data_v[2]), .tx_start(start_v[2]),
        .dataout_tx(dout_v[2]), .tx_busy(busy_v[2]), .tx_done(done_v[2])
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    function automatic logic exp_bit(input logic [7:0] data, input logic par, input int idx);
        if (idx == 0) return 1'b0;
        if (idx <= 8) return data[idx-1];
        if (idx == 9) return par;
        return 1'b1;
    endfunction

    logic [7:0] next_data;

    // Called just after the accepting edge; checks every cycle of the frame,
    // then the done pulse. inject: pulse tx_start mid-frame (must be ignored).
    // hold: keep tx_start high and present next_data for a back-to-back frame.
    task automatic check_frame(input int sel, input logic [7:0] data, input logic par,
                               input int len, input bit inject, input bit hold);
        int nbits;
        int bad;
        nbits = len / 16;
        for (int b = 0; b < nbits; b++) begin
            bad = 0;
            for (int k = 0; k < 16; k++) begin
                @(negedge clk);
                if (b == 0 && k == 0) begin
                    if (hold) data_v[sel] = next_data;
                    else      start_v[sel] = 1'b0;
                end
                if (inject && b * 16 + k == 50) begin
                    start_v[sel] = 1'b1;
                    data_v[sel]  = 8'h3C;
                end
                if (inject && b * 16 + k == 51) start_v[sel] = 1'b0;
                if (dout_v[sel] !== exp_bit(data, par, b) || busy_v[sel] !== 1'b1 ||
                    done_v[sel] !== 1'b0)
                    bad++;
            end
            chk($sformatf("frame_i%0d_d%02h_bit%0d_bad_cycles", sel, data, b), bad, 0);
        end
        @(negedge clk);
        chk($sformatf("done_pulse_i%0d_d%02h", sel, data), done_v[sel], 1);
        chk($sformatf("busy_end_i%0d_d%02h", sel, data), busy_v[sel], 0);
        chk($sformatf("line_end_i%0d_d%02h", sel, data), dout_v[sel], 1);
        if (!hold) begin
            @(negedge clk);
            chk($sformatf("done_clear_i%0d_d%02h", sel, data), done_v[sel], 0);
            chk($sformatf("idle_line_i%0d_d%02h", sel, data), dout_v[sel], 1);
        end
    endtask

    task automatic send(input int sel, input logic [7:0] data);
        @(negedge clk);
        start_v[sel] = 1'b1;
        data_v[sel]  = data;
        @(posedge clk);
    endtask

    typedef struct {
        int         sel;
        logic [7:0] data;
        logic       par;
        int         len;
    } vec_t;

    vec_t vecs[8];

    initial begin
        int bad;
        checks   = 0;
        failures = 0;
        vecs[0] = '{0, 8'h55, 1'b0, 176};
        vecs[1] = '{0, 8'h01, 1'b1, 176};
        vecs[2] = '{1, 8'h01, 1'b0, 176};
        vecs[3] = '{0, 8'hFF, 1'b0, 176};
        vecs[4] = '{2, 8'hA5, 1'b0, 192};
        vecs[5] = '{1, 8'h00, 1'b1, 176};
        vecs[6] = '{0, 8'h80, 1'b1, 176};
        vecs[7] = '{1, 8'h3C, 1'b1, 176};

        // Reset with tx_data unknown on the even instance
        rst       = 1'b1;
        start_v   = 3'b000;
        data_v[0] = 'x;
        data_v[1] = 8'h00;
        data_v[2] = 8'h00;
        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("reset_line_i%0d", i), dout_v[i], 1);
            chk($sformatf("reset_busy_i%0d", i), busy_v[i], 0);
            chk($sformatf("reset_done_i%0d", i), done_v[i], 0);
        end
        start_v[0] = 1'b1;
        data_v[0]  = 8'h00;
        @(posedge clk);
        @(negedge clk);
        chk("reset_overrides_start_busy", busy_v[0], 0);
        chk("reset_overrides_start_line", dout_v[0], 1);
        start_v[0] = 1'b0;
        data_v[0]  = 'x;
        rst        = 1'b0;

        for (int i = 0; i < 3; i++) begin
            bad = 0;
            for (int c = 0; c < 200; c++) begin
                @(negedge clk);
                if (dout_v[i] !== 1'b1 || busy_v[i] !== 1'b0 || done_v[i] !== 1'b0) bad++;
            end
            chk($sformatf("idle_after_reset_i%0d_bad_cycles", i), bad, 0);
        end

        for (int v = 0; v < 8; v++) begin
            send(vecs[v].sel, vecs[v].data);
            check_frame(vecs[v].sel, vecs[v].data, vecs[v].par, vecs[v].len, 1'b0, 1'b0);
        end

        // Start request while busy is ignored, and tx_data changes do not leak in
        send(0, 8'hA5);
        check_frame(0, 8'hA5, 1'b0, 176, 1'b1, 1'b0);
        bad = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (busy_v[0] !== 1'b0 || dout_v[0] !== 1'b1) bad++;
        end
        chk("ignored_start_no_queue_bad_cycles", bad, 0);

        // Back-to-back with tx_start held high: exactly one idle cycle between frames
        next_data = 8'h3C;
        send(0, 8'hA5);
        check_frame(0, 8'hA5, 1'b0, 176, 1'b0, 1'b1);
        @(posedge clk);
        #1;
        chk("b2b_gap_line", dout_v[0], 0);
        chk("b2b_gap_busy", busy_v[0], 1);
        check_frame(0, 8'h3C, 1'b0, 176, 1'b0, 1'b0);

        // Reset mid-frame at cycle 70
        send(0, 8'h5A);
        for (int c = 0; c < 70; c++) begin
            @(negedge clk);
            if (c == 0) start_v[0] = 1'b0;
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("midreset_line", dout_v[0], 1);
        chk("midreset_busy", busy_v[0], 0);
        chk("midreset_done", done_v[0], 0);
        @(negedge clk);
        rst = 1'b0;
        bad = 0;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (done_v[0] !== 1'b0 || busy_v[0] !== 1'b0 || dout_v[0] !== 1'b1) bad++;
        end
        chk("midreset_no_done_bad_cycles", bad, 0);
        send(0, 8'h81);
        check_frame(0, 8'h81, 1'b0, 176, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
